mips_multicycle_cpu: RTL and testbench
======================================

Name: mips_multicycle_cpu

Overview:
- Parametrised successor to the single-instruction-per-clock CPU.
- Multicycle MIPS-subset core. It executes a program supplied on a flattened instruction bus, with a configurable word count and register-file size.
- Adds start/halt control, a small data memory for lw/sw, beq/bne, illegal-opcode and fault detection, a retired-instruction counter, and a debug register read port.
- Sits as the top-level core under the CPU testbenches.

Parameters:
- IMEM_WORDS, 10, number of 32-bit instruction words on instr.
- DMEM_WORDS, 16, number of 32-bit data-memory words (power of 2).
- NUM_GR, 8, number of general registers (power of 2, 2..32); register fields with index >= NUM_GR are illegal.
- DATA_W, 32, datapath width; fixed at 32 in this generation.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from pc=0 when in IDLE or HALT.
- instr  in  32*IMEM_WORDS  program. Word i occupies instr[32*(IMEM_WORDS-i)-1 -: 32], so word 0 is the MSBs.
- dbg_sel  in  $clog2(NUM_GR)  register index for the debug read.
- dbg_data  out  32  gr[dbg_sel], combinational.
- pc  out  32  current program counter.
- ins  out  32  latched current instruction.
- busy  out  1  high in any state other than IDLE/HALT.
- halted  out  1  high in HALT.
- error  out  1  sticky fault flag; cleared by reset or start.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (next edge): state=IDLE. pc, ins, retired, error, all gr and all dmem are 0. busy=0, halted=0.
- gr[0] reads 0 always; writes to gr[0] are discarded.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE/HALT + start → FETCH. pc=0, retired=0, error=0. gr and dmem are retained. start in any other state is ignored.
- FETCH:
  - If pc[31:2] >= IMEM_WORDS → HALT, error stays 0 (normal end of program).
  - Otherwise ins <= word pc[31:2], → DECODE.
- DECODE: read rs/rt operands, sign-extend imm16.
  - Opcode/funct not in the set below, or rs/rt/rd >= NUM_GR → error=1, HALT.
- EXEC:
  - ALU operation.
  - Branch/jump resolves here: pc update, retired++, → FETCH.
  - lw/sw → MEM. All others → WB.
- Sequential pc = pc+4 is written in EXEC for non-control instructions.
- Supported instructions:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), sll 000000 (shamt).
  - addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- Arithmetic: add/sub/addi wrap modulo 2^32; no overflow trap. Word 0x00000000 is sll gr0 → nop.
- beq/bne taken: pc = pc+4 + (sext(imm)<<2). Not taken: pc+4.
- j: pc = {pc[31:28], target26, 2'b00}. Infinite loops are legal.
- MEM:
  - Address = rs + sext(imm).
  - If addr[1:0] != 0 or addr[31:2] >= DMEM_WORDS → error=1, HALT, with no write.
  - sw writes the word, retired++, → FETCH. lw → WB.
- WB: write rd (R-type) or rt (addi/lw), retired++, → FETCH.
- Latency in cycles, FETCH to next FETCH: R/addi 4, lw 5, sw 4, beq/bne/j 3.
- A faulting instruction does not increment retired, and pc keeps its address.
- reset asserted mid-instruction overrides everything; no partial writeback.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams.
  - FSM state encoding.
  - ALU-op encoding.
  - the instruction field slice positions.
- One sub-module, mips_alu: combinational, 32-bit, operations add/sub/and/or/slt/sll.

Test Plan:
- Program addi gr1,gr0,3; add gr2,gr1,gr1; addi gr3,gr2,1; add gr4,gr2,gr3; slt gr6,gr2,gr3; sub gr7,gr4,gr6, then nops with IMEM_WORDS=10; pulse start.
  - Required: gr1=3, gr2=6, gr3=7, gr4=13, gr6=1, gr7=12.
  - After the nops: halted=1, retired=10, pc=0x28, error=0.
- Cycle check: addi from FETCH to next FETCH takes 4 cycles; lw takes 5; beq/j take 3. Check the busy waveform.
- Branch/jump: beq gr1,gr1,+1 skips the next instruction (gr5 stays 0). A j to word 0 loops and retired keeps increasing. reset mid-loop → all outputs 0 on the next cycle.
- Memory: sw gr4 to address 8, then lw gr5 from address 8 → gr5=13.
  - lw at address 6 → error=1, halted=1, pc at the faulting instruction.
  - sw at address 64 with DMEM_WORDS=16 → error=1, dmem unchanged.
- Illegal opcode 111111 at word 2 → error=1, HALT, retired=2, gr state frozen. A subsequent start clears error and reruns from pc=0.
- Writes to gr0 (addi gr0,gr0,5) → dbg_data for dbg_sel=0 reads 0. NUM_GR=4 with rd=5 → error=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operations and instruction field positions.
package mips_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int TGT_LSB = 0;

  function automatic logic [2:0] alu_op_of(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU for the multicycle core.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  logic [2:0]  op_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLL: y_o = b_i << shamt_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// register file, small data memory, fault detection and a retire counter.
module mips_multicycle_cpu
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 10,
  parameter int DMEM_WORDS = 16,
  parameter int NUM_GR     = 8,
  parameter int DATA_W     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [32*IMEM_WORDS-1:0]  instr,
  input  logic [$clog2(NUM_GR)-1:0] dbg_sel,
  output logic [DATA_W-1:0]         dbg_data,
  output logic [31:0]               pc,
  output logic [31:0]               ins,
  output logic                      busy,
  output logic                      halted,
  output logic                      error,
  output logic [31:0]               retired
);

  localparam int          GR_AW      = $clog2(NUM_GR);
  localparam int          DM_AW      = $clog2(DMEM_WORDS);
  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
  localparam logic [29:0] DMEM_LIMIT = 30'(DMEM_WORDS);
  localparam logic [5:0]  GR_LIMIT   = 6'(NUM_GR);

  logic [2:0]        state_q, state_d;
  logic [31:0]       pc_q, pc_d, ins_q, ins_d, retired_q, retired_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] gr_q   [NUM_GR];
  logic [DATA_W-1:0] dmem_q [DMEM_WORDS];

  logic [5:0] opcode, funct;
  logic [4:0] rs_f, rt_f, rd_f, shamt;
  assign opcode = ins_q[OP_LSB +: 6];
  assign funct  = ins_q[FN_LSB +: 6];
  assign rs_f   = ins_q[RS_LSB +: 5];
  assign rt_f   = ins_q[RT_LSB +: 5];
  assign rd_f   = ins_q[RD_LSB +: 5];
  assign shamt  = ins_q[SH_LSB +: 5];

  // Index truncation is exact: DECODE has already rejected fields >= NUM_GR.
  logic [GR_AW-1:0] rs_idx, rt_idx, wb_idx;
  assign rs_idx = rs_f[GR_AW-1:0];
  assign rt_idx = rt_f[GR_AW-1:0];
  assign wb_idx = (opcode == OP_RTYPE) ? rd_f[GR_AW-1:0] : rt_f[GR_AW-1:0];

  function automatic logic reg_ok(input logic [4:0] f);
    return {1'b0, f} < GR_LIMIT;
  endfunction

  logic illegal;
  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OP_RTYPE: illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL})
                          || !reg_ok(rs_f) || !reg_ok(rt_f) || !reg_ok(rd_f);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
                illegal = !reg_ok(rs_f) || !reg_ok(rt_f);
      OP_J:     illegal = 1'b0;
      default:  illegal = 1'b1;
    endcase
  end

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_b, alu_y;
  assign alu_op = (opcode == OP_RTYPE) ? alu_op_of(funct) : ALU_ADD;
  assign alu_b  = (opcode == OP_RTYPE) ? b_q : imm_q;

  mips_alu u_alu (
    .a_i     (a_q),
    .b_i     (alu_b),
    .shamt_i (shamt),
    .op_i    (alu_op),
    .y_o     (alu_y)
  );

  logic [31:0] pc_plus4, br_target, j_target;
  logic        br_taken;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
  assign j_target  = {pc_q[31:28], ins_q[TGT_LSB +: 26], 2'b00};
  assign br_taken  = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  logic [DM_AW-1:0] dm_idx;
  logic             dm_fault;
  assign dm_idx   = alu_q[2 +: DM_AW];
  assign dm_fault = (alu_q[1:0] != 2'b00) || (alu_q[31:2] >= DMEM_LIMIT);

  logic [31:0]       fetch_word;
  logic [DATA_W-1:0] wb_data;
  logic              gr_we, dm_we;
  assign wb_data = (opcode == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    retired_d  = retired_q;
    error_d    = error_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    gr_we      = 1'b0;
    dm_we      = 1'b0;
    fetch_word = '0;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      if (pc_q[31:2] == 30'(i)) fetch_word = instr[32*(IMEM_WORDS-i)-1 -: 32];
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = '0;
          error_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (pc_q[31:2] >= IMEM_LIMIT) begin
          state_d = S_HALT;
        end else begin
          ins_d   = fetch_word;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          a_d     = gr_q[rs_idx];
          b_d     = gr_q[rt_idx];
          imm_d   = {{(DATA_W-16){ins_q[IMM_LSB+15]}}, ins_q[IMM_LSB +: 16]};
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_y;
        case (opcode)
          OP_BEQ, OP_BNE: begin
            pc_d      = br_taken ? br_target : pc_plus4;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
          OP_J: begin
            pc_d      = j_target;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
          OP_LW, OP_SW: begin
            pc_d    = pc_plus4;
            state_d = S_MEM;
          end
          default: begin
            pc_d    = pc_plus4;
            state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        // pc was advanced in EXEC; rewind so it points at the faulting access.
        if (dm_fault) begin
          error_d = 1'b1;
          pc_d    = pc_q - 32'd4;
          state_d = S_HALT;
        end else if (opcode == OP_SW) begin
          dm_we     = 1'b1;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          mdr_d   = dmem_q[dm_idx];
          state_d = S_WB;
        end
      end
      S_WB: begin
        gr_we     = (wb_idx != '0);
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with <= so every register samples pre-edge values
    // regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ins_q     <= '0;
      retired_q <= '0;
      error_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      // NOTE: both arrays must read zero after reset, so they are built from
      // resettable flops rather than a RAM macro.
      for (int i = 0; i < NUM_GR; i++) gr_q[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      retired_q <= retired_d;
      error_q   <= error_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      if (gr_we) gr_q[wb_idx] <= wb_data;
      if (dm_we) dmem_q[dm_idx] <= b_q;
    end
  end

  assign dbg_data = gr_q[dbg_sel];
  assign pc       = pc_q;
  assign ins      = ins_q;
  assign retired  = retired_q;
  assign error    = error_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: hand-assembled programs with
// hand-computed register, counter, pc and latency expectations.
module tb_mips_multicycle_cpu;

  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADD  = 6'b100000;
  localparam logic [5:0] T_SUB  = 6'b100010;
  localparam logic [5:0] T_AND  = 6'b100100;
  localparam logic [5:0] T_OR   = 6'b100101;
  localparam logic [5:0] T_SLT  = 6'b101010;
  localparam logic [5:0] T_SLL  = 6'b000000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         start4 = 1'b0;
  logic [319:0] instr = '0;
  logic [63:0]  instr4 = '0;
  logic [2:0]   dbg_sel = '0;
  logic [1:0]   dbg_sel4 = '0;
  logic [31:0]  dbg_data, pc, ins, retired;
  logic         busy, halted, error;
  logic [31:0]  dbg_data4, pc4, ins4, retired4;
  logic         busy4, halted4, error4;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] prog [10];
  int          chg_q [$];
  int          cyc, bcyc;
  int          exp_lat [7] = '{4, 4, 5, 3, 3, 4, 4};

  always #5 clock = ~clock;

  mips_multicycle_cpu #(.IMEM_WORDS(10), .DMEM_WORDS(16), .NUM_GR(8), .DATA_W(32)) u_dut (
    .clock(clock), .reset(reset), .start(start), .instr(instr), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .pc(pc), .ins(ins), .busy(busy), .halted(halted),
    .error(error), .retired(retired)
  );

  mips_multicycle_cpu #(.IMEM_WORDS(2), .DMEM_WORDS(16), .NUM_GR(4), .DATA_W(32)) u_dut4 (
    .clock(clock), .reset(reset), .start(start4), .instr(instr4), .dbg_sel(dbg_sel4),
    .dbg_data(dbg_data4), .pc(pc4), .ins(ins4), .busy(busy4), .halted(halted4),
    .error(error4), .retired(retired4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'b000010, 26'(target)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 10; i++) prog[i] = 32'h0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 10; i++) instr[32*(10-i)-1 -: 32] = prog[i];
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Counts edges after the start edge until halted, and logs the edge
  // indices at which pc changes (spacing equals per-instruction latency).
  task automatic wait_halt(input int max_cycles, output int cycles, output int busy_cycles);
    logic [31:0] prev_pc;
    cycles = 0;
    busy_cycles = 0;
    chg_q.delete();
    prev_pc = pc;
    while (!halted && cycles < max_cycles) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      cycles++;
      if (pc != prev_pc) begin
        chg_q.push_back(cycles);
        prev_pc = pc;
      end
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic run_to_halt(input int max_cycles, output int cycles, output int busy_cycles);
    pulse_start();
    wait_halt(max_cycles, cycles, busy_cycles);
  endtask

  task automatic check_gr(input string tag, input int idx, input logic [31:0] exp);
    dbg_sel = 3'(idx);
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_prog();
    load_prog();
    do_reset();
    check("rst_pc", pc, 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Arithmetic chain followed by nops; runs off the end of the program.
    clear_prog();
    prog[0] = enc_i(T_ADDI, 0, 1, 3);
    prog[1] = enc_r(1, 1, 2, 0, T_ADD);
    prog[2] = enc_i(T_ADDI, 2, 3, 1);
    prog[3] = enc_r(2, 3, 4, 0, T_ADD);
    prog[4] = enc_r(2, 3, 6, 0, T_SLT);
    prog[5] = enc_r(4, 6, 7, 0, T_SUB);
    load_prog();
    run_to_halt(200, cyc, bcyc);
    check_gr("p1_gr1", 1, 32'd3);
    check_gr("p1_gr2", 2, 32'd6);
    check_gr("p1_gr3", 3, 32'd7);
    check_gr("p1_gr4", 4, 32'd13);
    check_gr("p1_gr6", 6, 32'd1);
    check_gr("p1_gr7", 7, 32'd12);
    check("p1_retired", retired, 32'd10);
    check("p1_pc", pc, 32'h28);
    check("p1_error", 32'(error), 32'd0);
    check("p1_busy_after", 32'(busy), 32'd0);
    check("p1_cycles", 32'(cyc), 32'd41);
    check("p1_busy_cycles", 32'(bcyc), 32'd41);

    // Remaining ALU ops, signed slt, and a not-taken bne.
    clear_prog();
    prog[0] = enc_i(T_ADDI, 0, 1, -6);
    prog[1] = enc_i(T_ADDI, 0, 2, 12);
    prog[2] = enc_r(1, 2, 3, 0, T_AND);
    prog[3] = enc_r(1, 2, 4, 0, T_OR);
    prog[4] = enc_r(0, 2, 5, 3, T_SLL);
    prog[5] = enc_r(1, 2, 6, 0, T_SLT);
    prog[6] = enc_r(2, 1, 7, 0, T_SLT);
    prog[7] = enc_i(T_BNE, 1, 1, 1);
    prog[8] = enc_i(T_ADDI, 7, 7, 5);
    load_prog();
    run_to_halt(200, cyc, bcyc);
    check_gr("p8_gr1", 1, 32'hFFFF_FFFA);
    check_gr("p8_and", 3, 32'h0000_0008);
    check_gr("p8_or", 4, 32'hFFFF_FFFE);
    check_gr("p8_sll", 5, 32'h0000_0060);
    check_gr("p8_slt_neg", 6, 32'd1);
    check_gr("p8_bne_nt", 7, 32'd5);
    check("p8_retired", retired, 32'd10);

    // Memory round trip, taken beq, forward j, write to gr0, latency profile.
    clear_prog();
    prog[0] = enc_i(T_ADDI, 0, 4, 13);
    prog[1] = enc_i(T_SW, 0, 4, 8);
    prog[2] = enc_i(T_LW, 0, 5, 8);
    prog[3] = enc_i(T_BEQ, 4, 4, 1);
    prog[4] = enc_i(T_ADDI, 0, 5, 99);
    prog[5] = enc_j(7);
    prog[6] = enc_i(T_ADDI, 0, 5, 77);
    prog[7] = enc_i(T_ADDI, 0, 0, 5);
    load_prog();
    run_to_halt(200, cyc, bcyc);
    check_gr("p2_lw_gr5", 5, 32'd13);
    check_gr("p2_gr0", 0, 32'd0);
    check("p2_retired", retired, 32'd8);
    check("p2_pc", pc, 32'h28);
    check("p2_error", 32'(error), 32'd0);
    check("p2_cycles", 32'(cyc), 32'd32);
    check("p2_busy_cycles", 32'(bcyc), 32'd32);
    check("p2_pc_changes", 32'(chg_q.size()), 32'd8);
    if (chg_q.size() == 8) begin
      check("p2_first_exec", 32'(chg_q[0]), 32'd3);
      for (int i = 0; i < 7; i++)
        check($sformatf("p2_lat%0d", i), 32'(chg_q[i+1] - chg_q[i]), 32'(exp_lat[i]));
    end

    // Infinite loop via j, then reset mid-instruction.
    do_reset();
    clear_prog();
    prog[0] = enc_i(T_ADDI, 1, 1, 1);
    prog[1] = enc_j(0);
    load_prog();
    pulse_start();
    repeat (23) @(negedge clock);
    check("p3_loop_retired", retired, 32'd6);
    check("p3_loop_busy", 32'(busy), 32'd1);
    check("p3_loop_halted", 32'(halted), 32'd0);
    check_gr("p3_loop_gr1", 1, 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("p3_rst_pc", pc, 32'd0);
    check("p3_rst_ins", ins, 32'd0);
    check("p3_rst_retired", retired, 32'd0);
    check("p3_rst_error", 32'(error), 32'd0);
    check("p3_rst_busy", 32'(busy), 32'd0);
    check("p3_rst_halted", 32'(halted), 32'd0);
    check_gr("p3_rst_gr1", 1, 32'd0);
    reset = 1'b0;

    // Misaligned lw faults at the lw itself.
    do_reset();
    clear_prog();
    prog[0] = enc_i(T_ADDI, 0, 1, 5);
    prog[1] = enc_i(T_LW, 0, 2, 6);
    load_prog();
    run_to_halt(100, cyc, bcyc);
    check("p4_error", 32'(error), 32'd1);
    check("p4_pc", pc, 32'd4);
    check("p4_retired", retired, 32'd1);
    check("p4_cycles", 32'(cyc), 32'd8);
    check_gr("p4_gr2", 2, 32'd0);

    // Out-of-range sw faults without writing anything.
    do_reset();
    clear_prog();
    prog[0] = enc_i(T_ADDI, 0, 1, 5);
    prog[1] = enc_i(T_SW, 0, 1, 8);
    prog[2] = enc_i(T_SW, 0, 1, 64);
    load_prog();
    run_to_halt(100, cyc, bcyc);
    check("p5_error", 32'(error), 32'd1);
    check("p5_pc", pc, 32'd8);
    check("p5_retired", retired, 32'd2);

    // Restart without reset: error clears, gr and dmem are retained.
    clear_prog();
    prog[0] = enc_i(T_LW, 0, 3, 0);
    prog[1] = enc_i(T_LW, 0, 6, 8);
    load_prog();
    run_to_halt(200, cyc, bcyc);
    check("p6_error", 32'(error), 32'd0);
    check("p6_retired", retired, 32'd10);
    check("p6_cycles", 32'(cyc), 32'd43);
    check_gr("p6_dmem0", 3, 32'd0);
    check_gr("p6_dmem2", 6, 32'd5);
    check_gr("p6_gr1_kept", 1, 32'd5);

    // Illegal opcode at word 2, then rerun via start.
    do_reset();
    clear_prog();
    prog[0] = enc_i(T_ADDI, 0, 1, 1);
    prog[1] = enc_i(T_ADDI, 0, 2, 2);
    prog[2] = 32'hFC00_0000;
    prog[3] = enc_i(T_ADDI, 0, 3, 3);
    load_prog();
    run_to_halt(100, cyc, bcyc);
    check("p7_error", 32'(error), 32'd1);
    check("p7_retired", retired, 32'd2);
    check("p7_pc", pc, 32'd8);
    check_gr("p7_gr2", 2, 32'd2);
    check_gr("p7_gr3", 3, 32'd0);
    pulse_start();
    check("p7_restart_error", 32'(error), 32'd0);
    check("p7_restart_pc", pc, 32'd0);
    check("p7_restart_busy", 32'(busy), 32'd1);
    wait_halt(100, cyc, bcyc);
    check("p7_rerun_error", 32'(error), 32'd1);
    check("p7_rerun_retired", retired, 32'd2);
    check("p7_rerun_cycles", 32'(cyc), 32'd10);

    // Four-register variant: rd=5 is out of range.
    instr4 = {enc_i(T_ADDI, 0, 1, 2), enc_r(1, 1, 5, 0, T_ADD)};
    @(negedge clock); start4 = 1'b1;
    @(negedge clock); start4 = 1'b0;
    for (int i = 0; i < 50 && !halted4; i++) @(negedge clock);
    check("g4_halted", 32'(halted4), 32'd1);
    check("g4_error", 32'(error4), 32'd1);
    check("g4_retired", retired4, 32'd1);
    check("g4_pc", pc4, 32'd4);
    dbg_sel4 = 2'd1;
    #1;
    check("g4_gr1", dbg_data4, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
